// File: rtl/if_icache.sv
// IF stage: direct-mapped, one-word-per-line instruction cache.
// Hits issue to ID in one cycle; misses stall the PC and refill from memory.
module if_icache #(
  parameter int INDEX_LEN   = 7,
  parameter int ICACHE_SIZE = 128,
  parameter int TAG_LEN     = 30 - INDEX_LEN
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_in,
  input  logic        branch_in,
  input  logic [5:0]  stall_in,
  output logic        stall_req_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_data_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out
);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0]          data_arr [ICACHE_SIZE];
  logic [TAG_LEN-1:0]   tag_arr  [ICACHE_SIZE];
  logic [ICACHE_SIZE-1:0] valid_q;

  logic [INDEX_LEN-1:0] idx;
  logic [TAG_LEN-1:0]   tag;
  logic [INDEX_LEN-1:0] fill_idx;
  logic [TAG_LEN-1:0]   fill_tag;
  logic                 hit;
  logic                 fill;
  logic                 issue;
  logic                 start_miss;
  logic                 unused_bits;

  assign idx      = pc_in[INDEX_LEN+1:2];
  assign tag      = pc_in[31:INDEX_LEN+2];
  assign fill_idx = mem_addr_out[INDEX_LEN+1:2];
  assign fill_tag = mem_addr_out[31:INDEX_LEN+2];

  assign hit   = valid_q[idx] && (tag_arr[idx] == tag);
  assign fill  = (state_q == WAIT_MEM) && mem_ack_in;
  assign issue = (state_q == IDLE) && hit && !branch_in;

  assign unused_bits = ^{stall_in[5:2], stall_in[0], pc_in[1:0]};

  always_comb begin
    state_d       = state_q;
    stall_req_out = 1'b0;
    start_miss    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!hit && !branch_in) begin
          stall_req_out = 1'b1;
          start_miss    = 1'b1;
          state_d       = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        stall_req_out = 1'b1;
        if (mem_ack_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      mem_req_out    <= 1'b0;
      mem_addr_out   <= '0;
      inst_valid_out <= 1'b0;
      inst_out       <= '0;
      inst_pc_out    <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      if (start_miss) begin
        mem_req_out  <= 1'b1;
        mem_addr_out <= pc_in;
      end else if (fill) begin
        mem_req_out <= 1'b0;
      end
      if (fill) begin
        valid_q[fill_idx] <= 1'b1;
      end
      // a flush kills the output even while ID is stalled
      if (branch_in) begin
        inst_valid_out <= 1'b0;
      end else if (!stall_in[1]) begin
        inst_valid_out <= issue;
        if (issue) begin
          inst_out    <= data_arr[idx];
          inst_pc_out <= pc_in;
        end
      end
    end
  end

  // payload arrays carry no reset; valid_q guards them
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill) begin
      data_arr[fill_idx] <= mem_data_in;
      tag_arr[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: doc/if_icache.md
Name: if_icache

Overview:
- Instruction-fetch stage, directly downstream of the PC register.
- Takes the current fetch PC and looks it up in a direct-mapped instruction cache of one word per line.
- On a hit, registers the instruction and its PC towards decode.
- On a miss, stalls the PC through the stall controller, fetches the word from the memory controller, fills the line, then retries the lookup.

Parameters:
INDEX_LEN, 7, number of index bits; line index = pc[INDEX_LEN+1:2]
ICACHE_SIZE, 128, number of lines; must equal 2**INDEX_LEN
TAG_LEN, 30-INDEX_LEN, derived tag width; tag = pc[31:INDEX_LEN+2]

Ports:
clk_in  input  1  single clock, all state on rising edge
rst_in  input  1  asynchronous, active-high reset
rdy_in  input  1  global ready; when 0 all state frozen
pc_in  input  32  fetch address from PC stage, word aligned
branch_in  input  1  branch taken/flush from EX
stall_in  input  6  stall vector from stall control; bit1 = hold IF outputs
stall_req_out  output  1  request to stall control to freeze PC (combinational)
mem_req_out  output  1  memory read request, held until ack
mem_addr_out  output  32  word address of the request
mem_ack_in  input  1  one-cycle pulse: mem_data_in valid
mem_data_in  input  32  fetched instruction word
inst_valid_out  output  1  inst_out/inst_pc_out valid to ID
inst_out  output  32  instruction to ID
inst_pc_out  output  32  PC of inst_out

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE; all ICACHE_SIZE valid bits cleared.
  - mem_req_out=0, mem_addr_out=0.
  - inst_valid_out=0, inst_out=0, inst_pc_out=0.
  - Data/tag arrays are not reset.
  - Reset mid-miss abandons the request; mem_req_out drops immediately.
- rdy_in=0: no register, array or state change; stall_req_out still driven.
- hit = valid[idx] && tag_arr[idx]==tag(pc_in), combinational.
- State IDLE:
  - Hit, not stalled, no branch: next edge registers inst_valid_out=1, inst_out=data_arr[idx], inst_pc_out=pc_in. Hit latency is one cycle, back-to-back at one per cycle.
  - Miss: stall_req_out=1 in the same cycle. Next edge: state=WAIT_MEM, mem_req_out=1, mem_addr_out=pc_in, inst_valid_out=0.
- State WAIT_MEM:
  - stall_req_out=1; mem_req_out and mem_addr_out stay stable until mem_ack_in.
  - On mem_ack_in: write data_arr/tag_arr at the index of mem_addr_out and set valid. Then mem_req_out=0, state=IDLE.
  - The following IDLE cycle hits and issues. Miss penalty = memory latency + 2 cycles.
- stall_in[1]=1 (decode stalled):
  - inst_* outputs hold their values.
  - stall_req_out is unaffected; the PC is frozen by the stall controller anyway.
  - A miss may still start and refill while stalled.
- branch_in=1 (priority over everything except reset/rdy):
  - Next edge inst_valid_out=0.
  - In IDLE, no miss is started that cycle.
  - In WAIT_MEM the outstanding request is not cancelled. The refill completes and writes the cache, but nothing is issued. Afterwards return to IDLE and look up the new pc_in.
  - branch_in coinciding with mem_ack_in: fill is written, no issue, state=IDLE.
- Index wrap: addresses differing only in tag map to the same line; a refill overwrites (no associativity).
- Simultaneous hit and stall_in[1]: outputs hold; the instruction is not consumed. pc_in is also held (stall), so it reissues on release.

Test Plan:
- Cold miss: reset, pc_in=0x0, memory latency 3, data 0x00000013 -> stall_req_out=1 at once; mem_req_out=1 with addr 0x0 until ack. Two cycles after ack: inst_valid_out=1, inst_out=0x00000013, inst_pc_out=0x0.
- Warm hits: prefill 0x0–0xC, then pc_in steps 0x0,0x4,0x8,0xC -> four consecutive valid outputs, one per cycle, stall_req_out=0 throughout.
- Conflict: fill 0x004, then fetch 0x204 (same index, INDEX_LEN=7) -> miss and refill; a subsequent fetch of 0x004 misses again.
- Branch during miss: miss at 0x40, branch_in=1 before ack, new pc_in=0x80 -> no output for 0x40. Line 0x40 is valid afterwards, and a 0x80 miss follows.
- Stall/rdy: on a hit assert stall_in[1]=1 for 3 cycles -> inst_* unchanged. rdy_in=0 mid-WAIT_MEM with ack withheld -> state and outputs frozen; resumes correctly after rdy_in=1.
- Async reset mid-miss: assert rst_in between clock edges during WAIT_MEM -> mem_req_out=0 and inst_valid_out=0 immediately; first fetch after release misses.
